regs_bank: RTL and testbench

- Parametrised successor register file for the NRISC core. Clocked storage, generic width/depth/read-port count, two write ports:
  - port A: ALU writeback, one cycle.
  - port B: memory/load writeback, late.
- Write-to-read bypass and a per-register busy scoreboard for outstanding loads.
- Sits between decode (read addresses, busy check) and the two writeback paths; the hazard unit consumes `rd_busy`.

---
 rtl/nrisc_pkg.sv | 13 +
 rtl/regs_bank_rdport.sv | 52 +++++
 rtl/regs_bank.sv | 121 ++++++++++++
 tb/tb_regs_bank.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared NRISC register-file definitions: default geometry, register index type, r0 constant.
// Pure declarations; no logic, no latency.
package nrisc_pkg;

    localparam int TAM_DEF  = 16;
    localparam int NREG_DEF = 16;
    localparam int IDX_W    = $clog2(NREG_DEF);

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regs_bank_rdport.sv
// One combinational read port: A-bypass > B-bypass > stored value, plus busy qualification.
// Zero latency; no backpressure.
module regs_bank_rdport
    import nrisc_pkg::*;
#(
    parameter int TAM     = TAM_DEF,
    parameter int NREG    = NREG_DEF,
    parameter bit ZERO_R0 = 1'b1,
    parameter int AW      = $clog2(NREG)
) (
    input  logic                 rst,
    input  logic [AW-1:0]        rd_addr,
    input  logic [NREG*TAM-1:0]  regs_flat,
    input  logic [NREG-1:0]      busy,
    input  logic                 wa_commit,
    input  logic [AW-1:0]        wa_addr,
    input  logic [TAM-1:0]       wa_data,
    input  logic                 wb_commit,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [TAM-1:0]       wb_data,
    input  logic                 busy_set_en,
    input  logic [AW-1:0]        busy_set_addr,
    output logic [TAM-1:0]       rd_data,
    output logic                 rd_busy
);

    logic is_zero;
    logic load_arrives;
    logic load_reissued;

    assign is_zero       = ZERO_R0 && (rd_addr == AW'(REG_ZERO));
    assign load_arrives  = wb_en && (wb_addr == rd_addr);
    assign load_reissued = busy_set_en && (busy_set_addr == rd_addr);

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (rst && !is_zero) begin
            if (wa_commit && (wa_addr == rd_addr)) begin
                rd_data = wa_data;
            end else if (wb_commit && (wb_addr == rd_addr)) begin
                rd_data = wb_data;
            end else begin
                rd_data = regs_flat[rd_addr*TAM +: TAM];
            end
            // A load landing now is forwarded, unless a new load to the same register is issued too
            rd_busy = busy[rd_addr] && !(load_arrives && !load_reissued);
        end
    end

endmodule

// File: rtl/regs_bank.sv
// NRISC register file: two write ports (A=ALU, B=load), NREAD bypassed read ports, load scoreboard.
// Writes commit on rising clk; reads are zero-latency; no backpressure.
module regs_bank
    import nrisc_pkg::*;
#(
    parameter int TAM     = TAM_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NREAD   = 2,
    parameter bit ZERO_R0 = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wa_en,
    input  logic [AW-1:0]        wa_addr,
    input  logic [TAM-1:0]       wa_data,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [TAM-1:0]       wb_data,
    input  logic                 busy_set_en,
    input  logic [AW-1:0]        busy_set_addr,
    input  logic [NREAD*AW-1:0]  rd_addr,
    output logic [NREAD*TAM-1:0] rd_data,
    output logic [NREAD-1:0]     rd_busy,
    output logic                 waw_err
);

    if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
        $error("regs_bank: NREG must be a power of two and at least 2");
    end
    if (NREAD < 1) begin : g_bad_nread
        $error("regs_bank: NREAD must be at least 1");
    end

    logic [TAM-1:0]      regs_q [NREG];
    logic [TAM-1:0]      regs_d [NREG];
    logic [NREG-1:0]     busy_q;
    logic [NREG-1:0]     busy_d;
    logic                waw_err_q;
    logic                waw_err_d;
    logic [NREG*TAM-1:0] regs_flat;

    logic wa_commit;
    logic wb_commit;
    logic set_commit;

    assign wa_commit  = rst && wa_en       && !(ZERO_R0 && (wa_addr == AW'(REG_ZERO)));
    assign wb_commit  = rst && wb_en       && !(ZERO_R0 && (wb_addr == AW'(REG_ZERO)));
    assign set_commit = rst && busy_set_en && !(ZERO_R0 && (busy_set_addr == AW'(REG_ZERO)));

    always_comb begin
        regs_d = regs_q;
        if (wb_commit) begin
            regs_d[wb_addr] = wb_data;
        end
        if (wa_commit) begin
            regs_d[wa_addr] = wa_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        // Set after clear: a load reissued in the same cycle keeps the register busy
        if (set_commit) begin
            busy_d[busy_set_addr] = 1'b1;
        end
    end

    always_comb begin
        waw_err_d = waw_err_q || (wa_commit && busy_q[wa_addr]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            waw_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            waw_err_q <= waw_err_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*TAM +: TAM] = regs_q[g];
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        regs_bank_rdport #(
            .TAM     (TAM),
            .NREG    (NREG),
            .ZERO_R0 (ZERO_R0),
            .AW      (AW)
        ) u_rdport (
            .rst           (rst),
            .rd_addr       (rd_addr[k*AW +: AW]),
            .regs_flat     (regs_flat),
            .busy          (busy_q),
            .wa_commit     (wa_commit),
            .wa_addr       (wa_addr),
            .wa_data       (wa_data),
            .wb_commit     (wb_commit),
            .wb_en         (wb_en),
            .wb_addr       (wb_addr),
            .wb_data       (wb_data),
            .busy_set_en   (busy_set_en),
            .busy_set_addr (busy_set_addr),
            .rd_data       (rd_data[k*TAM +: TAM]),
            .rd_busy       (rd_busy[k])
        );
    end

    assign waw_err = waw_err_q;

endmodule

// File: tb/tb_regs_bank.sv
// Scoreboard bench for regs_bank: directed scenarios followed by a randomised phase against a reference model.
module tb_regs_bank;

    localparam int TAM   = 16;
    localparam int NREG  = 16;
    localparam int NREAD = 2;
    localparam int AW    = 4;

    localparam int K_RD0   = 0;
    localparam int K_RD1   = 1;
    localparam int K_BUSY0 = 2;
    localparam int K_BUSY1 = 3;
    localparam int K_WAW   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wa_en;
    logic [AW-1:0]        wa_addr;
    logic [TAM-1:0]       wa_data;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [TAM-1:0]       wb_data;
    logic                 busy_set_en;
    logic [AW-1:0]        busy_set_addr;
    logic [NREAD*AW-1:0]  rd_addr;
    logic [NREAD*TAM-1:0] rd_data;
    logic [NREAD-1:0]     rd_busy;
    logic                 waw_err;

    typedef struct {
        string       tag;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [15:0] m_reg [NREG];
    bit          m_busy [NREG];
    bit          m_waw;

    always #5 clk = ~clk;

    regs_bank #(
        .TAM     (TAM),
        .NREG    (NREG),
        .NREAD   (NREAD),
        .ZERO_R0 (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wa_en         (wa_en),
        .wa_addr       (wa_addr),
        .wa_data       (wa_data),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_busy       (rd_busy),
        .waw_err       (waw_err)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [15:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Samples mid-low-phase, well away from the rising edge.
    task automatic drain();
        exp_t        e;
        logic [15:0] act;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RD0:   act = rd_data[15:0];
                K_RD1:   act = rd_data[31:16];
                K_BUSY0: act = {15'd0, rd_busy[0]};
                K_BUSY1: act = {15'd0, rd_busy[1]};
                default: act = {15'd0, waw_err};
            endcase
            check(e.tag, act, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        busy_set_en = 1'b0; busy_set_addr = '0;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    function automatic logic [15:0] model_rd(input int a);
        if (a == 0) return 16'h0;
        if (wa_en && int'(wa_addr) == a) return wa_data;
        if (wb_en && int'(wb_addr) == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic [15:0] model_busy(input int a);
        bit b;
        b = m_busy[a] && !(wb_en && int'(wb_addr) == a && !(busy_set_en && int'(busy_set_addr) == a));
        return {15'd0, b};
    endfunction

    initial begin
        idle();
        rst = 1'b0;
        rd(5, 0);
        @(negedge clk);

        // Reset state
        expect_val("rst_rd0", K_RD0, 16'h0);
        expect_val("rst_busy0", K_BUSY0, 16'h0);
        expect_val("rst_waw", K_WAW, 16'h0);
        drain();
        step();
        step();

        // Write r5, mark r6 busy, then reset overrides a concurrent write
        rst = 1'b1;
        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 16'h1234;
        busy_set_en = 1'b1; busy_set_addr = 4'd6;
        step();
        idle();
        rd(5, 6);
        expect_val("pre_rst_r5", K_RD0, 16'h1234);
        expect_val("pre_rst_r6_busy", K_BUSY1, 16'h1);
        drain();
        rst = 1'b0;
        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 16'h5555;
        expect_val("in_rst_rd0", K_RD0, 16'h0);
        expect_val("in_rst_busy1", K_BUSY1, 16'h0);
        drain();
        step();
        step();
        rst = 1'b1;
        idle();
        expect_val("post_rst_r5", K_RD0, 16'h0);
        expect_val("post_rst_r6_busy", K_BUSY1, 16'h0);
        expect_val("post_rst_waw", K_WAW, 16'h0);
        drain();

        // Port A bypass on both read ports
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 16'hBEEF;
        rd(3, 3);
        expect_val("bypA_p0", K_RD0, 16'hBEEF);
        expect_val("bypA_p1", K_RD1, 16'hBEEF);
        drain();
        step();
        idle();
        expect_val("storeA_r3", K_RD0, 16'hBEEF);
        drain();

        // Port B bypass alone, then A/B collision
        wb_en = 1'b1; wb_addr = 4'd8; wb_data = 16'h2222;
        rd(3, 8);
        expect_val("bypB_p1", K_RD1, 16'h2222);
        expect_val("bypB_p0_other", K_RD0, 16'hBEEF);
        drain();
        step();
        wa_en = 1'b1; wa_addr = 4'd7; wa_data = 16'h1111;
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'h2222;
        rd(7, 8);
        expect_val("coll_byp", K_RD0, 16'h1111);
        expect_val("storeB_r8", K_RD1, 16'h2222);
        drain();
        step();
        idle();
        expect_val("coll_store", K_RD0, 16'h1111);
        drain();

        // Scoreboard set at n, visible n+1..n+2, cleared by load at n+3
        busy_set_en = 1'b1; busy_set_addr = 4'd4;
        rd(4, 4);
        expect_val("sb_n_busy", K_BUSY0, 16'h0);
        drain();
        step();
        idle();
        expect_val("sb_n1_busy", K_BUSY0, 16'h1);
        drain();
        step();
        expect_val("sb_n2_busy", K_BUSY1, 16'h1);
        drain();
        step();
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'hCAFE;
        expect_val("sb_n3_busy", K_BUSY0, 16'h0);
        expect_val("sb_n3_data", K_RD0, 16'hCAFE);
        drain();
        step();
        idle();
        expect_val("sb_n4_busy", K_BUSY0, 16'h0);
        expect_val("sb_n4_data", K_RD1, 16'hCAFE);
        drain();

        // Set/clear race on the same register
        busy_set_en = 1'b1; busy_set_addr = 4'd4;
        step();
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h0A0A;
        busy_set_en = 1'b1; busy_set_addr = 4'd4;
        expect_val("race_busy", K_BUSY0, 16'h1);
        expect_val("race_data", K_RD0, 16'h0A0A);
        drain();
        step();
        idle();
        expect_val("race_next_busy", K_BUSY0, 16'h1);
        expect_val("race_next_data", K_RD1, 16'h0A0A);
        drain();
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h0B0B;
        step();
        idle();

        // Register 0 stays zero and never busy
        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 16'hFFFF;
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hEEEE;
        busy_set_en = 1'b1; busy_set_addr = 4'd0;
        rd(0, 4);
        expect_val("r0_byp", K_RD0, 16'h0);
        expect_val("r0_busy", K_BUSY0, 16'h0);
        expect_val("r4_cleared", K_BUSY1, 16'h0);
        drain();
        step();
        idle();
        expect_val("r0_store", K_RD0, 16'h0);
        expect_val("r0_busy_next", K_BUSY0, 16'h0);
        expect_val("r0_no_waw", K_WAW, 16'h0);
        drain();

        // Write-after-load hazard sets the sticky error
        busy_set_en = 1'b1; busy_set_addr = 4'd9;
        step();
        idle();
        wa_en = 1'b1; wa_addr = 4'd9; wa_data = 16'h9999;
        rd(9, 0);
        expect_val("waw_same_cycle", K_WAW, 16'h0);
        expect_val("waw_byp", K_RD0, 16'h9999);
        drain();
        step();
        idle();
        expect_val("waw_set", K_WAW, 16'h1);
        expect_val("waw_data", K_RD0, 16'h9999);
        expect_val("waw_still_busy", K_BUSY0, 16'h1);
        drain();
        step();
        step();
        expect_val("waw_sticky", K_WAW, 16'h1);
        drain();
        rst = 1'b0;
        step();
        rst = 1'b1;
        expect_val("waw_cleared", K_WAW, 16'h0);
        drain();

        // Randomised traffic against the reference model
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_waw = 1'b0;
        for (int c = 0; c < 300; c++) begin
            int a0;
            int a1;
            bit hazard;
            wa_en         = ($urandom_range(0, 2) == 0);
            wa_addr       = AW'($urandom_range(0, NREG - 1));
            wa_data       = 16'($urandom());
            wb_en         = ($urandom_range(0, 2) == 0);
            wb_addr       = AW'($urandom_range(0, NREG - 1));
            wb_data       = 16'($urandom());
            busy_set_en   = ($urandom_range(0, 3) == 0);
            busy_set_addr = AW'($urandom_range(0, NREG - 1));
            a0 = $urandom_range(0, NREG - 1);
            a1 = $urandom_range(0, NREG - 1);
            rd(a0, a1);
            expect_val("rnd_rd0", K_RD0, model_rd(a0));
            expect_val("rnd_rd1", K_RD1, model_rd(a1));
            expect_val("rnd_busy0", K_BUSY0, model_busy(a0));
            expect_val("rnd_busy1", K_BUSY1, model_busy(a1));
            expect_val("rnd_waw", K_WAW, {15'd0, m_waw});
            drain();

            hazard = wa_en && wa_addr != 0 && m_busy[wa_addr];
            if (hazard) m_waw = 1'b1;
            if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
            if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (busy_set_en && busy_set_addr != 0) m_busy[busy_set_addr] = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
